// File: rtl/rom_phase_reader_pkg.sv
// Shared memory helpers for the dual-port ROM wavetable readers.
// Address-width derivation and quadrature offset folding live here so every user agrees on them.
package rom_phase_reader_pkg;

  function automatic int unsigned addr_width(input int unsigned depth);
    return $clog2(depth);
  endfunction

  // Port B offset folded into the table range so wrap happens in address bits.
  function automatic int unsigned quad_offset_mod(input int unsigned offset,
                                                  input int unsigned depth);
    return offset % depth;
  endfunction

  function automatic bit depth_is_valid(input int unsigned depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/rom_phase_accumulator.sv
// Phase accumulator for the wavetable reader: load/increment on issue cycles,
// derives the port A (sin) and port B (cos, quarter-table ahead) ROM addresses.
module rom_phase_accumulator
  import rom_phase_reader_pkg::*;
#(
  parameter int unsigned Depth        = 1024,
  parameter int unsigned PhaseWidth   = 32,
  parameter int unsigned QuadOffset   = Depth / 4,
  parameter int unsigned AddressWidth = addr_width(Depth)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    issue,
  input  logic                    enable,
  input  logic                    load,
  input  logic [PhaseWidth-1:0]   load_value,
  input  logic [PhaseWidth-1:0]   phase_inc,
  output logic [AddressWidth-1:0] addr_a,
  output logic [AddressWidth-1:0] addr_b
);

  localparam logic [AddressWidth-1:0] QuadAddr =
    AddressWidth'(quad_offset_mod(QuadOffset, Depth));

  logic [PhaseWidth-1:0] phase_q;
  logic [PhaseWidth-1:0] phase_d;

  // A load pending outside an issue cycle is dropped; the caller holds it.
  always_comb begin
    phase_d = phase_q;
    if (issue) begin
      if (load) begin
        phase_d = load_value;
      end else if (enable) begin
        phase_d = phase_q + phase_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign addr_a = phase_q[PhaseWidth-1 -: AddressWidth];
  assign addr_b = addr_a + QuadAddr;

endmodule

// File: rtl/rom_phase_reader.sv
// Quadrature wavetable reader: drives both ROM ports from one phase accumulator
// and presents the captured sin/cos pair as a valid/ready stream without loss.
module rom_phase_reader
  import rom_phase_reader_pkg::*;
#(
  parameter int unsigned Width        = 16,
  parameter int unsigned Depth        = 1024,
  parameter int unsigned PhaseWidth   = 32,
  parameter int unsigned QuadOffset   = Depth / 4,
  parameter int unsigned AddressWidth = addr_width(Depth)
) (
  input  logic                    ipClk,
  input  logic                    ipReset,
  input  logic                    ipEnable,
  input  logic [PhaseWidth-1:0]   ipPhaseInc,
  input  logic                    ipPhaseLoad,
  input  logic [PhaseWidth-1:0]   ipPhaseValue,
  output logic                    opRomClkEnable,
  output logic [AddressWidth-1:0] opRomAddress_A,
  output logic [AddressWidth-1:0] opRomAddress_B,
  input  logic [Width-1:0]        ipRomData_A,
  input  logic [Width-1:0]        ipRomData_B,
  output logic                    opValid,
  input  logic                    ipReady,
  output logic [Width-1:0]        opSin,
  output logic [Width-1:0]        opCos
);

  logic             s1_valid_q;
  logic             s1_valid_d;
  logic             valid_q;
  logic             valid_d;
  logic [Width-1:0] sin_q;
  logic [Width-1:0] sin_d;
  logic [Width-1:0] cos_q;
  logic [Width-1:0] cos_d;
  logic             load_out;
  logic             issue;

  // The ROM output itself is the stage-1 buffer: gating its clock enable
  // freezes the address, so stalled data simply waits on the ROM pins.
  assign load_out       = s1_valid_q & (~valid_q | ipReady);
  assign issue          = ~s1_valid_q | load_out;
  assign opRomClkEnable = issue;

  rom_phase_accumulator #(
    .Depth        (Depth),
    .PhaseWidth   (PhaseWidth),
    .QuadOffset   (QuadOffset),
    .AddressWidth (AddressWidth)
  ) u_acc (
    .clk        (ipClk),
    .rst_n      (ipReset),
    .issue      (issue),
    .enable     (ipEnable),
    .load       (ipPhaseLoad),
    .load_value (ipPhaseValue),
    .phase_inc  (ipPhaseInc),
    .addr_a     (opRomAddress_A),
    .addr_b     (opRomAddress_B)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    valid_d    = valid_q;
    sin_d      = sin_q;
    cos_d      = cos_q;
    if (issue) begin
      s1_valid_d = ipEnable;
    end
    if (load_out) begin
      valid_d = 1'b1;
      sin_d   = ipRomData_A;
      cos_d   = ipRomData_B;
    end else if (ipReady) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      s1_valid_q <= 1'b0;
      valid_q    <= 1'b0;
      sin_q      <= '0;
      cos_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      valid_q    <= valid_d;
      sin_q      <= sin_d;
      cos_q      <= cos_d;
    end
  end

  assign opValid = valid_q;
  assign opSin   = sin_q;
  assign opCos   = cos_q;

endmodule

// File: tb/tb_rom_phase_reader.sv
// Directed bench for rom_phase_reader against an identity-content ROM model.
module tb_rom_phase_reader;

  logic        ipClk = 1'b0;
  logic        ipReset;
  logic        ipEnable;
  logic [31:0] ipPhaseInc;
  logic        ipPhaseLoad;
  logic [31:0] ipPhaseValue;
  logic        opRomClkEnable;
  logic [9:0]  opRomAddress_A;
  logic [9:0]  opRomAddress_B;
  logic [15:0] ipRomData_A;
  logic [15:0] ipRomData_B;
  logic        opValid;
  logic        ipReady;
  logic [15:0] opSin;
  logic [15:0] opCos;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned got_sin[$];
  int unsigned got_cos[$];
  logic [9:0]  rom_ra = '0;
  logic [9:0]  rom_rb = '0;
  logic [15:0] lfsr   = 16'hACE1;

  always #5 ipClk = ~ipClk;

  rom_phase_reader #(
    .Width      (16),
    .Depth      (1024),
    .PhaseWidth (32),
    .QuadOffset (256)
  ) dut (
    .ipClk          (ipClk),
    .ipReset        (ipReset),
    .ipEnable       (ipEnable),
    .ipPhaseInc     (ipPhaseInc),
    .ipPhaseLoad    (ipPhaseLoad),
    .ipPhaseValue   (ipPhaseValue),
    .opRomClkEnable (opRomClkEnable),
    .opRomAddress_A (opRomAddress_A),
    .opRomAddress_B (opRomAddress_B),
    .ipRomData_A    (ipRomData_A),
    .ipRomData_B    (ipRomData_B),
    .opValid        (opValid),
    .ipReady        (ipReady),
    .opSin          (opSin),
    .opCos          (opCos)
  );

  // Dual-port ROM: registered address, unregistered data, word[i] = i.
  always @(posedge ipClk) begin
    if (opRomClkEnable) begin
      rom_ra <= opRomAddress_A;
      rom_rb <= opRomAddress_B;
    end
  end
  assign ipRomData_A = {6'b0, rom_ra};
  assign ipRomData_B = {6'b0, rom_rb};

  task automatic check(input string tag, input longint unsigned got, input longint unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs are stable between post-edge drive and the next edge, so the
  // negedge view is exactly what the next posedge will see.
  always @(negedge ipClk) begin
    if (ipReset === 1'b1) begin
      if (opValid && ipReady) begin
        got_sin.push_back(int'(opSin));
        got_cos.push_back(int'(opCos));
      end
      if (opValid && !ipReady && dut.s1_valid_q)
        check("stall_clk_enable", opRomClkEnable, 0);
    end
  end

  task automatic tick();
    @(posedge ipClk);
    #1;
  endtask

  task automatic clear_q();
    got_sin.delete();
    got_cos.delete();
  endtask

  task automatic drain();
    ipEnable = 1'b0;
    ipReady  = 1'b1;
    repeat (4) tick();
    clear_q();
  endtask

  task automatic load_phase(input logic [31:0] value);
    ipEnable     = 1'b0;
    ipPhaseLoad  = 1'b1;
    ipPhaseValue = value;
    tick();
    ipPhaseLoad  = 1'b0;
  endtask

  task automatic wait_samples(input string tag, input int n, input bit random_ready);
    for (int i = 0; i < 400 && got_sin.size() < n; i++) begin
      if (random_ready) begin
        lfsr    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        ipReady = lfsr[0];
      end
      tick();
    end
    check({tag, "_collected"}, got_sin.size() >= n, 1);
  endtask

  // Expected sample k from start phase p0: top 10 bits of p0 + k*inc.
  task automatic compare_seq(input string tag, input int n, input logic [31:0] p0,
                             input logic [31:0] inc);
    logic [31:0] ph;
    logic [9:0]  a;
    for (int k = 0; k < n; k++) begin
      ph = p0 + inc * k;
      a  = ph[31:22];
      check($sformatf("%s_sin[%0d]", tag, k), (k < got_sin.size()) ? got_sin[k] : 32'hFFFF_FFFF, a);
      check($sformatf("%s_cos[%0d]", tag, k), (k < got_cos.size()) ? got_cos[k] : 32'hFFFF_FFFF,
            10'(a + 10'd256));
    end
  endtask

  initial begin
    ipReset      = 1'b0;
    ipEnable     = 1'b0;
    ipPhaseInc   = 32'h0040_0000;
    ipPhaseLoad  = 1'b0;
    ipPhaseValue = '0;
    ipReady      = 1'b1;
    tick();
    tick();
    check("rst_valid", opValid, 0);
    check("rst_sin", opSin, 0);
    check("rst_cos", opCos, 0);
    check("rst_addr_a", opRomAddress_A, 0);
    check("rst_addr_b", opRomAddress_B, 256);
    ipReset = 1'b1;
    tick();

    // Latency and streaming from phase 0.
    ipEnable = 1'b1;
    tick();
    check("latency_n", opValid, 0);
    tick();
    check("latency_n1_valid", opValid, 1);
    check("latency_n1_sin", opSin, 0);
    check("latency_n1_cos", opCos, 256);
    wait_samples("stream", 8, 0);
    compare_seq("stream", 8, 32'h0, 32'h0040_0000);
    drain();

    // Wrap across the table end.
    load_phase(32'hFFC0_0000);
    ipEnable = 1'b1;
    wait_samples("wrap", 3, 0);
    compare_seq("wrap", 3, 32'hFFC0_0000, 32'h0040_0000);
    check("wrap_sin0", got_sin[0], 1023);
    check("wrap_cos0", got_cos[0], 255);
    drain();

    // Load to half-table.
    load_phase(32'h8000_0000);
    ipEnable = 1'b1;
    wait_samples("load", 2, 0);
    check("load_sin", got_sin[0], 512);
    check("load_cos", got_cos[0], 768);
    compare_seq("load", 2, 32'h8000_0000, 32'h0040_0000);
    drain();

    // Backpressure: sequence must match the no-stall run.
    load_phase(32'h0);
    ipEnable = 1'b1;
    wait_samples("bp", 20, 1);
    compare_seq("bp", 20, 32'h0, 32'h0040_0000);
    drain();

    // Enable gap of three issue cycles.
    load_phase(32'h0);
    ipEnable = 1'b1;
    repeat (4) tick();
    ipEnable = 1'b0;
    repeat (3) tick();
    ipEnable = 1'b1;
    wait_samples("gap", 8, 0);
    compare_seq("gap", 8, 32'h0, 32'h0040_0000);
    drain();

    // Asynchronous reset mid-stream while stalled on a non-zero sample.
    load_phase(32'h4000_0000);
    ipReady  = 1'b0;
    ipEnable = 1'b1;
    for (int i = 0; i < 20 && !opValid; i++) tick();
    check("pre_rst_valid", opValid, 1);
    check("pre_rst_sin", opSin, 256);
    tick();
    #2;
    ipReset = 1'b0;
    #1;
    check("async_rst_valid", opValid, 0);
    check("async_rst_sin", opSin, 0);
    check("async_rst_cos", opCos, 0);
    check("async_rst_addr_a", opRomAddress_A, 0);
    check("async_rst_addr_b", opRomAddress_B, 256);
    ipEnable = 1'b0;
    ipReady  = 1'b1;
    tick();
    tick();
    ipReset = 1'b1;
    clear_q();
    tick();
    ipEnable = 1'b1;
    wait_samples("restart", 4, 0);
    compare_seq("restart", 4, 32'h0, 32'h0040_0000);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
